// File: rtl/decode_stage_pkg.sv
// Purpose : shared decode constants, ImmSrc encoding, ID/EX payload struct, immediate helper.
// Latency : n/a (types and pure functions only).
// Backpressure: n/a.
package decode_stage_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 32;

    // Opcodes of the supported instruction subset
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // ALUControl encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ResultSrc encodings
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    // Everything the ID/EX register carries into execute
    typedef struct packed {
        logic              reg_write;
        logic [1:0]        result_src;
        logic              mem_write;
        logic              jump;
        logic              branch;
        logic [2:0]        alu_control;
        logic              alu_src;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm_ext;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_plus4;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
    } idex_t;

    // Sign-extend the immediate field selected by src; sign always comes from instr[31]
    function automatic logic [XLEN-1:0] imm_extend(input logic [XLEN-1:0] instr,
                                                   input imm_src_e        src);
        logic [XLEN-1:0] imm;
        case (src)
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = {{20{instr[31]}}, instr[31:20]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/register_file.sv
// Purpose : 32x32 register file, two combinational read ports, one write port; x0 reads 0.
// Latency : reads combinational, write visible after the rising edge (or same cycle with REGFILE_BYPASS_EN).
// Backpressure: none; a write is accepted every cycle we=1 and rd_addr!=0.
// Ports   : clk, reset (async active-low, clears all entries), rs1_addr/rs2_addr -> rs1_dat/rs2_dat,
//           we/rd_addr/wr_dat write port. Optional macro: REGFILE_BYPASS_EN (write-to-read forwarding).
module register_file
    import decode_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic              we,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [XLEN-1:0]   wr_dat,
    output logic [XLEN-1:0]   rs1_dat,
    output logic [XLEN-1:0]   rs2_dat
);

    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            mem_d[i] = mem_q[i];
        end
        // x0 is never written, so it stays at its reset value of 0
        if (we && (rd_addr != '0)) begin
            mem_d[rd_addr] = wr_dat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight writeback so a same-cycle read sees the new value
    always_comb begin
        rs1_dat = '0;
        rs2_dat = '0;
        if (rs1_addr != '0) begin
            rs1_dat = (we && (rs1_addr == rd_addr)) ? wr_dat : mem_q[rs1_addr];
        end
        if (rs2_addr != '0) begin
            rs2_dat = (we && (rs2_addr == rd_addr)) ? wr_dat : mem_q[rs2_addr];
        end
    end
`else
    // Same-cycle read returns the pre-write value; the hazard unit stalls to cover it
    always_comb begin
        rs1_dat = (rs1_addr == '0) ? '0 : mem_q[rs1_addr];
        rs2_dat = (rs2_addr == '0) ? '0 : mem_q[rs2_addr];
    end
`endif

endmodule

// File: rtl/decode_stage.sv
// Purpose : RV32 decode stage - control decode, immediate extension, register file read, ID/EX register.
// Latency : 1 cycle InstrD -> E outputs; Rs1D/Rs2D are combinational.
// Backpressure: none; ID/EX loads every cycle, FlushE loads a bubble (all zeros).
// Ports   : clk, reset (async active-low); InstrD/PCD/PCPlus4D from fetch; RegWriteW/RdW/ResultW writeback;
//           FlushE; Rs1D/Rs2D to hazard unit; *E registered outputs. Optional macro: REGFILE_BYPASS_EN.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   InstrD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RdW,
    input  logic [XLEN-1:0]   ResultW,
    input  logic              FlushE,
    output logic [REG_AW-1:0] Rs1D,
    output logic [REG_AW-1:0] Rs2D,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              JumpE,
    output logic              BranchE,
    output logic              ALUSrcE,
    output logic [1:0]        ResultSrcE,
    output logic [2:0]        ALUControlE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [REG_AW-1:0] Rs1E,
    output logic [REG_AW-1:0] Rs2E,
    output logic [REG_AW-1:0] RdE
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [XLEN-1:0] rd1_dat;
    logic [XLEN-1:0] rd2_dat;
    imm_src_e        imm_src;
    idex_t           ctl;
    idex_t           idex_d;
    idex_t           idex_q;

    assign opcode   = InstrD[6:0];
    assign funct3   = InstrD[14:12];
    assign funct7b5 = InstrD[30];
    assign Rs1D     = InstrD[19:15];
    assign Rs2D     = InstrD[24:20];

    register_file u_register_file (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (Rs1D),
        .rs2_addr (Rs2D),
        .we       (RegWriteW),
        .rd_addr  (RdW),
        .wr_dat   (ResultW),
        .rs1_dat  (rd1_dat),
        .rs2_dat  (rd2_dat)
    );

    // Control decode; unknown opcodes fall through as an all-zero bubble
    always_comb begin
        ctl     = '0;
        imm_src = IMM_I;
        case (opcode)
            OP_LW: begin
                ctl.reg_write  = 1'b1;
                ctl.alu_src    = 1'b1;
                ctl.result_src = RES_MEM;
            end
            OP_SW: begin
                ctl.mem_write = 1'b1;
                ctl.alu_src   = 1'b1;
                imm_src       = IMM_S;
            end
            OP_RTYPE, OP_IALU: begin
                ctl.reg_write = 1'b1;
                ctl.alu_src   = (opcode == OP_IALU);
                case (funct3)
                    // funct7b5 only means sub for R-type; for I-ALU bit 30 is immediate data
                    3'b000:  ctl.alu_control = (opcode == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ctl.alu_control = ALU_SLT;
                    3'b110:  ctl.alu_control = ALU_OR;
                    3'b111:  ctl.alu_control = ALU_AND;
                    default: ctl.alu_control = ALU_ADD;
                endcase
            end
            OP_BEQ: begin
                ctl.branch      = 1'b1;
                ctl.alu_control = ALU_SUB;
                imm_src         = IMM_B;
            end
            OP_JAL: begin
                ctl.reg_write  = 1'b1;
                ctl.jump       = 1'b1;
                ctl.result_src = RES_PC4;
                imm_src        = IMM_J;
            end
            default: ;
        endcase
    end

    always_comb begin
        idex_d          = ctl;
        idex_d.rd1      = rd1_dat;
        idex_d.rd2      = rd2_dat;
        idex_d.imm_ext  = imm_extend(InstrD, imm_src);
        idex_d.pc       = PCD;
        idex_d.pc_plus4 = PCPlus4D;
        idex_d.rs1      = Rs1D;
        idex_d.rs2      = Rs2D;
        idex_d.rd       = InstrD[11:7];
        if (FlushE) begin
            idex_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign RegWriteE   = idex_q.reg_write;
    assign MemWriteE   = idex_q.mem_write;
    assign JumpE       = idex_q.jump;
    assign BranchE     = idex_q.branch;
    assign ALUSrcE     = idex_q.alu_src;
    assign ResultSrcE  = idex_q.result_src;
    assign ALUControlE = idex_q.alu_control;
    assign RD1E        = idex_q.rd1;
    assign RD2E        = idex_q.rd2;
    assign ImmExtE     = idex_q.imm_ext;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pc_plus4;
    assign Rs1E        = idex_q.rs1;
    assign Rs2E        = idex_q.rs2;
    assign RdE         = idex_q.rd;

endmodule

// File: tb/tb_decode_stage.sv
// Purpose : directed self-checking bench for decode_stage with hand-computed expectations.
// Latency : checks E outputs 1 ns after each rising edge; inputs change between edges.
// Backpressure: n/a. Honours REGFILE_BYPASS_EN for the same-cycle write/read case.
module tb_decode_stage;

    logic        clk;
    logic        reset;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        FlushE;
    logic [4:0]  Rs1D, Rs2D;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;

    int total = 0;
    int bad   = 0;

    decode_stage dut (
        .clk         (clk),
        .reset       (reset),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .RegWriteW   (RegWriteW),
        .RdW         (RdW),
        .ResultW     (ResultW),
        .FlushE      (FlushE),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .JumpE       (JumpE),
        .BranchE     (BranchE),
        .ALUSrcE     (ALUSrcE),
        .ResultSrcE  (ResultSrcE),
        .ALUControlE (ALUControlE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmExtE     (ImmExtE),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write one register through the writeback port, leaving the port idle afterwards
    task automatic wb_write(input logic [4:0] idx, input logic [31:0] val);
        RegWriteW = 1'b1;
        RdW       = idx;
        ResultW   = val;
        tick();
        RegWriteW = 1'b0;
        RdW       = '0;
        ResultW   = '0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset     = 1'b0;
        InstrD    = 32'h0050_0093;   // addi x1, x0, 5
        PCD       = 32'h0000_0010;
        PCPlus4D  = 32'h0000_0014;
        RegWriteW = 1'b0;
        RdW       = '0;
        ResultW   = '0;
        FlushE    = 1'b0;

        // Held in reset: outputs stay zero across edges
        tick();
        tick();
        chk("rst_regwrite", {31'd0, RegWriteE}, 32'd0);
        chk("rst_imm",      ImmExtE,            32'd0);
        chk("rst_rd",       {27'd0, RdE},       32'd0);
        chk("rst_pc",       PCE,                32'd0);
        chk("rst_alusrc",   {31'd0, ALUSrcE},   32'd0);

        // First edge after release captures normally
        reset = 1'b1;
        tick();
        chk("addi_imm",    ImmExtE,            32'd5);
        chk("addi_alusrc", {31'd0, ALUSrcE},   32'd1);
        chk("addi_regwr",  {31'd0, RegWriteE}, 32'd1);
        chk("addi_rd",     {27'd0, RdE},       32'd1);
        chk("addi_pc4",    PCPlus4E,           32'h14);

        // x3 = DEADBEEF, then add x1, x2, x3
        InstrD = 32'h0000_0000;
        wb_write(5'd3, 32'hDEAD_BEEF);
        InstrD = 32'h0031_00B3;
        #1;
        chk("add_rs1d", {27'd0, Rs1D}, 32'd2);
        chk("add_rs2d", {27'd0, Rs2D}, 32'd3);
        tick();
        chk("add_rd2",    RD2E,                 32'hDEAD_BEEF);
        chk("add_rd1",    RD1E,                 32'd0);
        chk("add_aluctl", {29'd0, ALUControlE}, 32'd0);
        chk("add_ressrc", {30'd0, ResultSrcE},  32'd0);
        chk("add_rs2e",   {27'd0, Rs2E},        32'd3);

        // Write to x0 is dropped, including while it is being read
        wb_write(5'd0, 32'h0000_1234);
        RegWriteW = 1'b1;
        RdW       = 5'd0;
        ResultW   = 32'h0000_1234;
        InstrD    = 32'h0000_00B3;   // add x1, x0, x0
        tick();
        RegWriteW = 1'b0;
        chk("x0_rd1", RD1E, 32'd0);
        chk("x0_rd2", RD2E, 32'd0);

        // beq x0, x0, -4
        InstrD   = 32'hFE00_0EE3;
        PCD      = 32'h0000_0040;
        PCPlus4D = 32'h0000_0044;
        tick();
        chk("beq_branch", {31'd0, BranchE},     32'd1);
        chk("beq_aluctl", {29'd0, ALUControlE}, 32'd1);
        chk("beq_imm",    ImmExtE,              32'hFFFF_FFFC);
        chk("beq_pc",     PCE,                  32'h40);
        chk("beq_regwr",  {31'd0, RegWriteE},   32'd0);

        // jal x1, 8
        InstrD = 32'h0080_00EF;
        tick();
        chk("jal_jump",   {31'd0, JumpE},       32'd1);
        chk("jal_ressrc", {30'd0, ResultSrcE},  32'd2);
        chk("jal_imm",    ImmExtE,              32'd8);
        chk("jal_aluctl", {29'd0, ALUControlE}, 32'd0);

        // ori x2, x1, -1
        InstrD = 32'hFFF0_E113;
        tick();
        chk("ori_aluctl", {29'd0, ALUControlE}, 32'd3);
        chk("ori_imm",    ImmExtE,              32'hFFFF_FFFF);

        // andi x2, x1, 7
        InstrD = 32'h0070_F113;
        tick();
        chk("andi_aluctl", {29'd0, ALUControlE}, 32'd2);

        // sub x1, x2, x3
        InstrD = 32'h4031_00B3;
        tick();
        chk("sub_aluctl", {29'd0, ALUControlE}, 32'd1);
        chk("sub_alusrc", {31'd0, ALUSrcE},     32'd0);

        // slt x1, x2, x3
        InstrD = 32'h0031_20B3;
        tick();
        chk("slt_aluctl", {29'd0, ALUControlE}, 32'd5);

        // addi x1, x0, 0x400: bit 30 set but I-type stays add
        InstrD = 32'h4000_0093;
        tick();
        chk("addi7_aluctl", {29'd0, ALUControlE}, 32'd0);
        chk("addi7_imm",    ImmExtE,              32'h400);

        // R-type funct3=001 (sll) is unsupported by the ALU set: add
        InstrD = 32'h0031_10B3;
        tick();
        chk("sll_aluctl", {29'd0, ALUControlE}, 32'd0);

        // sw x3, 8(x0)
        InstrD = 32'h0030_2423;
        PCD    = 32'h0000_0080;
        tick();
        chk("sw_memwr", {31'd0, MemWriteE}, 32'd1);
        chk("sw_imm",   ImmExtE,            32'd8);
        chk("sw_rd2",   RD2E,               32'hDEAD_BEEF);
        chk("sw_regwr", {31'd0, RegWriteE}, 32'd0);

        // Same sw flushed: full bubble
        FlushE = 1'b1;
        tick();
        FlushE = 1'b0;
        chk("fl_memwr", {31'd0, MemWriteE}, 32'd0);
        chk("fl_regwr", {31'd0, RegWriteE}, 32'd0);
        chk("fl_rd2",   RD2E,               32'd0);
        chk("fl_imm",   ImmExtE,            32'd0);
        chk("fl_pc",    PCE,                32'd0);
        chk("fl_rs2",   {27'd0, Rs2E},      32'd0);

        // Unknown opcode decodes to a bubble
        InstrD = 32'h0000_007F;
        tick();
        chk("unk_regwr", {31'd0, RegWriteE}, 32'd0);
        chk("unk_alusrc", {31'd0, ALUSrcE},  32'd0);

        // x5 = 0x11, then write 0x77 while add x6, x5, x0 reads it
        wb_write(5'd5, 32'h0000_0011);
        RegWriteW = 1'b1;
        RdW       = 5'd5;
        ResultW   = 32'h0000_0077;
        InstrD    = 32'h0002_8333;
        tick();
        RegWriteW = 1'b0;
`ifdef REGFILE_BYPASS_EN
        chk("same_cyc_rd1", RD1E, 32'h77);
`else
        chk("same_cyc_rd1", RD1E, 32'h11);
`endif
        tick();
        chk("after_wr_rd1", RD1E, 32'h77);

        // Reset mid-operation with a pending write to x7
        RegWriteW = 1'b1;
        RdW       = 5'd7;
        ResultW   = 32'h0000_0099;
        reset     = 1'b0;
        #1;
        chk("mid_rst_rd1",   RD1E,               32'd0);
        chk("mid_rst_regwr", {31'd0, RegWriteE}, 32'd0);
        tick();
        RegWriteW = 1'b0;
        reset     = 1'b1;
        InstrD    = 32'h0033_8433;   // add x8, x7, x3
        tick();
        chk("post_rst_x7", RD1E, 32'd0);
        chk("post_rst_x3", RD2E, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-low; clock clk.
REQ-003 InstrD  input  32  instruction from the fetch-stage register.
REQ-004 PCD, PCPlus4D  input  32 each  PC and PC+4 of InstrD.
REQ-005 RegWriteW  input  1  writeback enable.
REQ-006 RdW  input  5  writeback register index.
REQ-007 ResultW  input  32  writeback data.
REQ-008 FlushE  input  1  synchronous bubble insert into the ID/EX register.
REQ-009 Rs1D, Rs2D  output  5 each  combinational source indices, driven to the hazard unit.
REQ-010 RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  output  1 each  registered control signals.
REQ-011 ResultSrcE  output  2  registered result select: 00 ALU, 01 memory, 10 PC+4.
REQ-012 ALUControlE  output  3  registered ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-013 RD1E, RD2E, ImmExtE, PCE, PCPlus4E  output  32 each  registered datapath values.
REQ-014 Rs1E, Rs2E, RdE  output  5 each  registered register indices.

Function
REQ-015 Decoding SHALL use opcode InstrD[6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7b5 [30].
REQ-016 Supported opcodes SHALL be 0000011 lw, 0100011 sw, 0110011 R-type, 0010011 I-ALU, 1100011 beq, 1101111 jal.
REQ-017 Any other opcode SHALL decode to all control signals 0, i.e. a bubble.
REQ-018 Immediate extension SHALL be sign-extended from InstrD[31]: I {[31:20]}, S {[31:25],[11:7]}, B {[31],[7],[30:25],[11:8],0}, J {[31],[19:12],[20],[30:21],0}.
REQ-019 ALUControl SHALL be add for lw/sw/jal and sub for beq.
REQ-020 For R-type and I-ALU, funct3 000 SHALL select add, except sub when R-type and funct7b5=1.
REQ-021 For R-type and I-ALU, funct3 010 SHALL select slt, 110 or, 111 and; other funct3 values SHALL select add.
REQ-022 The register file SHALL hold 32x32-bit entries with two combinational read ports and one write port.
REQ-023 The register file SHALL write on the rising clk edge when RegWriteW=1 and RdW!=0.
REQ-024 Reads of x0 SHALL return 0 at all times, and writes to x0 SHALL be discarded.
REQ-025 The ID/EX register SHALL capture all decoded and datapath values every rising edge, giving a latency of 1 cycle from InstrD to the E outputs.
REQ-026 When FlushE=1 at an edge, all E outputs SHALL load 0 (a bubble) regardless of InstrD.
REQ-027 The stage SHALL have no stall input; the ID/EX register loads every cycle.

Reset
REQ-028 When reset=0, every ID/EX output SHALL clear to 0 asynchronously.
REQ-029 When reset=0, all 32 register-file entries SHALL clear to 0 asynchronously.
REQ-030 Reset asserted mid-operation SHALL discard any pending writeback in that cycle.
REQ-031 The first rising edge after reset deasserts SHALL perform normal capture.

Configuration
REQ-032 Macro REGFILE_BYPASS_EN, when defined, SHALL make a read of index Rs1D or Rs2D return ResultW combinationally if it equals RdW, RegWriteW=1 and the index is nonzero.
REQ-033 Without REGFILE_BYPASS_EN, a same-cycle read SHALL return the pre-write value, and the hazard unit stalls fetch and decode by one cycle to cover this.

Structure
REQ-034 A shared package SHALL hold the opcode constants, the ALUControl encodings, the ResultSrc encodings and the ImmSrc encoding typedef (00 I, 01 S, 10 B, 11 J).
REQ-035 The register file SHALL be a separate sub-module named register_file; control decode and immediate extension SHALL be inline logic.

Verification
REQ-036 Hold reset=0 and drive InstrD=0x00500093 -> all E outputs stay 0; after release, the next edge gives ImmExtE=5, ALUSrcE=1, RegWriteE=1, RdE=1.
REQ-037 Write RdW=3, ResultW=0xDEADBEEF, then drive InstrD=0x003100B3 (add x1,x2,x3) -> RD2E=0xDEADBEEF, ALUControlE=000, ResultSrcE=00.
REQ-038 Write RdW=0 with ResultW=0x1234 and RegWriteW=1, then read x0 -> RD1E=0.
REQ-039 Drive InstrD=0xFE000EE3 (beq x0,x0,-4) with PCD=0x40 -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFFC, PCE=0x40.
REQ-040 Drive FlushE=1 with a valid sw instruction -> MemWriteE=0, RegWriteE=0 and all data outputs 0 at the next edge.
REQ-041 Write x5=0x77 in the same cycle that x5 is read -> RD1E=0x77 with REGFILE_BYPASS_EN defined, or the old value without it.
